// File: rtl/qspi_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_arb_pkg
//  Description : Shared types and constants for the QSPI request arbiter.
//                Holds the arbiter state encoding, the grant encodings and
//                the default values of the arbiter parameters, plus small
//                helper functions used for sizing and winner selection.
//  Revision    : 1.0 - initial release
// ============================================================================
package qspi_arb_pkg;

    // Arbiter sequencing states (3-bit encoding, 6 states used).
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_ISSUE      = 3'd1,
        ST_WAIT_START = 3'd2,
        ST_ACTIVE     = 3'd3,
        ST_ACK        = 3'd4,
        ST_GAP        = 3'd5
    } arb_state_t;

    // Grant encodings as seen on the grant output.
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_IND  = 2'b01;
    localparam logic [1:0] GNT_MM   = 2'b10;

    // Default parameter values.
    localparam int DEF_STARVE_MAX     = 4;
    localparam int DEF_GAP_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

    // Bits needed for a counter that runs 0 .. n-1 (never less than 1 bit).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Memory-mapped traffic has default priority; indirect wins only when
    // it is the sole requester or it has been starved for too long.
    function automatic logic pick_indirect(input logic ind_req,
                                           input logic mm_req,
                                           input logic starved);
        return ind_req && (!mm_req || starved);
    endfunction

endpackage : qspi_arb_pkg
`default_nettype wire

// File: rtl/qspi_request_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_request_arbiter_if
//  Description : Bundle of request, protocol-controller handshake and grant
//                signals around the QSPI request arbiter.
//                  master : requesters + protocol controller side
//                  slave  : the arbiter itself
//                Inputs to the arbiter : qspi_en, ind_req, mm_req, mm_addr,
//                                        qspi_busy, qspi_done
//                Outputs from arbiter  : qspi_basic_mode_req,
//                                        memory_mapped_mode_req,
//                                        memory_mapped_mode_addr, ind_ack,
//                                        mm_ack, grant, arb_busy, timeout_err
//  Revision    : 1.0 - initial release
// ============================================================================
interface qspi_request_arbiter_if;

    logic        qspi_en;
    logic        ind_req;
    logic        mm_req;
    logic [31:0] mm_addr;
    logic        qspi_busy;
    logic        qspi_done;

    logic        qspi_basic_mode_req;
    logic        memory_mapped_mode_req;
    logic [31:0] memory_mapped_mode_addr;
    logic        ind_ack;
    logic        mm_ack;
    logic [1:0]  grant;
    logic        arb_busy;
    logic        timeout_err;

    modport master (
        output qspi_en, ind_req, mm_req, mm_addr, qspi_busy, qspi_done,
        input  qspi_basic_mode_req, memory_mapped_mode_req,
               memory_mapped_mode_addr, ind_ack, mm_ack, grant, arb_busy,
               timeout_err
    );

    modport slave (
        input  qspi_en, ind_req, mm_req, mm_addr, qspi_busy, qspi_done,
        output qspi_basic_mode_req, memory_mapped_mode_req,
               memory_mapped_mode_addr, ind_ack, mm_ack, grant, arb_busy,
               timeout_err
    );

endinterface : qspi_request_arbiter_if
`default_nettype wire

// File: rtl/qspi_arb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_arb_timer
//  Description : Loadable up-counter with a terminal flag. The count stops
//                at TERM_VAL so the flag stays asserted until reloaded.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                i_load        - load i_load_val (has priority over count)
//                i_load_val    - value loaded by i_load
//                i_en          - count enable
//                o_term        - count equals TERM_VAL
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_arb_timer #(
    parameter int WIDTH    = 4,
    parameter int TERM_VAL = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_term
);

    localparam logic [WIDTH-1:0] c_TERM = WIDTH'(TERM_VAL);

    logic [WIDTH-1:0] r_count;
    logic             w_term;

    assign w_term = (r_count == c_TERM);
    assign o_term = w_term;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && !w_term) begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule : qspi_arb_timer
`default_nettype wire

// File: rtl/qspi_request_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : qspi_request_arbiter
//  Description : Shares the single QSPI protocol engine between indirect
//                (configuration register) transfers and memory-mapped (AHB)
//                reads. Each granted request is sequenced as: one-cycle start
//                pulse, wait for busy, wait for done (with timeout), one-cycle
//                ack to the requester, then an idle gap before the next grant.
//                Memory-mapped requests have default priority; an indirect
//                request pending across STARVE_MAX consecutive MM grants is
//                forced through next.
//  Ports       : sys_clk, sys_rst - clock, synchronous active-high reset
//                bus (slave)      - requests, protocol handshake, grant/acks
//  Parameters  : STARVE_MAX     - MM grants tolerated while indirect waits
//                GAP_CYCLES     - idle cycles after each ack (min 1)
//                TIMEOUT_CYCLES - cycles allowed in WAIT_START + ACTIVE
//  Revision    : 1.0 - initial release
// ============================================================================
module qspi_request_arbiter
    import qspi_arb_pkg::*;
#(
    parameter int STARVE_MAX     = DEF_STARVE_MAX,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
    qspi_request_arbiter_if.slave  bus
);

    localparam int c_STARVE_W = cnt_width(STARVE_MAX + 1);
    localparam int c_GAP_W    = cnt_width(GAP_CYCLES);
    localparam int c_TMO_W    = cnt_width(TIMEOUT_CYCLES);

    localparam logic [c_STARVE_W-1:0] c_STARVE_TOP = c_STARVE_W'(STARVE_MAX);

    // ------------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------------
    arb_state_t              r_state;
    logic [1:0]              r_grant;
    logic [31:0]             r_addr;
    logic                    r_basic_req;
    logic                    r_mm_req;
    logic                    r_ind_ack;
    logic                    r_mm_ack;
    logic                    r_arb_busy;
    logic                    r_timeout_err;
    logic [c_STARVE_W-1:0]   r_starve_cnt;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic w_any_req;
    logic w_pick_ind;
    logic w_tmo_load;
    logic w_tmo_en;
    logic w_tmo_term;
    logic w_gap_load;
    logic w_gap_en;
    logic w_gap_term;

    assign w_any_req  = bus.ind_req || bus.mm_req;
    assign w_pick_ind = pick_indirect(bus.ind_req, bus.mm_req,
                                      r_starve_cnt == c_STARVE_TOP);

    // The timeout counter is zeroed while in ISSUE so that it reads 0 on the
    // first WAIT_START cycle; the gap counter likewise is zeroed in ACK.
    assign w_tmo_load = (r_state == ST_ISSUE);
    assign w_tmo_en   = (r_state == ST_WAIT_START) || (r_state == ST_ACTIVE);
    assign w_gap_load = (r_state == ST_ACK);
    assign w_gap_en   = (r_state == ST_GAP);

    qspi_arb_timer #(
        .WIDTH    (c_TMO_W),
        .TERM_VAL (TIMEOUT_CYCLES - 1)
    ) u_tmo_timer (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .i_load     (w_tmo_load),
        .i_load_val ({c_TMO_W{1'b0}}),
        .i_en       (w_tmo_en),
        .o_term     (w_tmo_term)
    );

    qspi_arb_timer #(
        .WIDTH    (c_GAP_W),
        .TERM_VAL (GAP_CYCLES - 1)
    ) u_gap_timer (
        .clk        (sys_clk),
        .rst        (sys_rst),
        .i_load     (w_gap_load),
        .i_load_val ({c_GAP_W{1'b0}}),
        .i_en       (w_gap_en),
        .o_term     (w_gap_term)
    );

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= GNT_NONE;
            r_addr        <= '0;
            r_basic_req   <= 1'b0;
            r_mm_req      <= 1'b0;
            r_ind_ack     <= 1'b0;
            r_mm_ack      <= 1'b0;
            r_arb_busy    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_starve_cnt  <= '0;
        end else begin
            // Pulse outputs default low; each is raised for a single cycle.
            r_basic_req   <= 1'b0;
            r_mm_req      <= 1'b0;
            r_ind_ack     <= 1'b0;
            r_mm_ack      <= 1'b0;
            r_timeout_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.qspi_en && w_any_req) begin
                        r_state    <= ST_ISSUE;
                        r_arb_busy <= 1'b1;
                        if (w_pick_ind) begin
                            r_grant <= GNT_IND;
                        end else begin
                            r_grant <= GNT_MM;
                            r_addr  <= bus.mm_addr;
                        end
                    end
                end

                ST_ISSUE: begin
                    r_basic_req <= (r_grant == GNT_IND);
                    r_mm_req    <= (r_grant == GNT_MM);
                    r_state     <= ST_WAIT_START;
                end

                ST_WAIT_START: begin
                    // done without busy is a zero-length transfer; a done on
                    // the terminal cycle beats the timeout.
                    if (bus.qspi_done && !bus.qspi_busy) begin
                        r_ind_ack <= (r_grant == GNT_IND);
                        r_mm_ack  <= (r_grant == GNT_MM);
                        r_state   <= ST_ACK;
                    end else if (w_tmo_term) begin
                        r_ind_ack     <= (r_grant == GNT_IND);
                        r_mm_ack      <= (r_grant == GNT_MM);
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_ACK;
                    end else if (bus.qspi_busy) begin
                        r_state <= ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    if (bus.qspi_done) begin
                        r_ind_ack <= (r_grant == GNT_IND);
                        r_mm_ack  <= (r_grant == GNT_MM);
                        r_state   <= ST_ACK;
                    end else if (w_tmo_term) begin
                        r_ind_ack     <= (r_grant == GNT_IND);
                        r_mm_ack      <= (r_grant == GNT_MM);
                        r_timeout_err <= 1'b1;
                        r_state       <= ST_ACK;
                    end
                end

                ST_ACK: begin
                    // Count MM grants that bypassed a waiting indirect
                    // request; any other completion clears the history.
                    if ((r_grant == GNT_MM) && bus.ind_req) begin
                        if (r_starve_cnt != c_STARVE_TOP) begin
                            r_starve_cnt <= r_starve_cnt + 1'b1;
                        end
                    end else begin
                        r_starve_cnt <= '0;
                    end
                    r_grant <= GNT_NONE;
                    r_state <= ST_GAP;
                end

                ST_GAP: begin
                    if (w_gap_term) begin
                        r_arb_busy <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end

                default: begin
                    r_grant    <= GNT_NONE;
                    r_arb_busy <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output mapping
    // ------------------------------------------------------------------------
    assign bus.qspi_basic_mode_req     = r_basic_req;
    assign bus.memory_mapped_mode_req  = r_mm_req;
    assign bus.memory_mapped_mode_addr = r_addr;
    assign bus.ind_ack                 = r_ind_ack;
    assign bus.mm_ack                  = r_mm_ack;
    assign bus.grant                   = r_grant;
    assign bus.arb_busy                = r_arb_busy;
    assign bus.timeout_err             = r_timeout_err;

endmodule : qspi_request_arbiter
`default_nettype wire
